epass_validator: RTL and testbench
==================================

# epass_validator

Upstream stage of `non_stop_ETC`: validates the E-pass tag read while a vehicle occupies sensor 2 and drives the 2-bit `valid_Epass` verdict consumed by the toll controller. On a sensor-2 rising edge it waits for a tag frame, sequentially searches a small on-chip account table, deducts the toll on a match with sufficient balance, and holds the verdict until sensor 2 clears.

## Interface
- `TAG_W`, 8, tag ID width
- `BAL_W`, 16, account balance width (unsigned)
- `N_ACCT`, 8, account table entries (power of 2, ≥2)
- `TOLL`, 50, fee deducted per valid pass
- `TAG_TIMEOUT`, 64, cycles to wait for a tag after sensor-2 rise

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `sensor2` in 1: vehicle present at reader
- `tag_valid` in 1: one-cycle strobe, `tag_id` valid
- `tag_id` in TAG_W: tag read from the RFID front end
- `acct_wr_en` in 1: provisioning write strobe
- `acct_wr_idx` in $clog2(N_ACCT): entry index
- `acct_wr_tag` in TAG_W: tag stored in entry
- `acct_wr_bal` in BAL_W: balance stored in entry (entry marked valid)
- `acct_rd_idx` in $clog2(N_ACCT): debug read index
- `acct_rd_bal` out BAL_W: combinational balance of `acct_rd_idx`
- `acct_busy` out 1: high when state ≠ IDLE
- `valid_Epass` out 2: verdict, `00` none, `01` unknown tag/timeout, `10` charged, `11` insufficient balance
- `charge_done` out 1: one-cycle pulse when a toll is deducted
- `charge_tag` out TAG_W: tag last charged (held)

## Operation
- `sensor2` registered once (`s2_q`); rise = `sensor2 & ~s2_q`, fall = `~sensor2 & s2_q`.
- States: IDLE, WAIT_TAG, SEARCH, CHARGE, HOLD.
- IDLE: `valid_Epass=00`; rise → WAIT_TAG, timeout counter cleared.
- WAIT_TAG: `tag_valid` → latch `tag_id`, index=0 → SEARCH. Counter reaches TAG_TIMEOUT → HOLD with `01`. Fall → IDLE.
- SEARCH: one entry per cycle; valid entry with matching tag → CHARGE (lowest index wins on duplicates). Index N_ACCT-1 without match → HOLD with `01`. Fall → IDLE, no charge.
- CHARGE: balance ≥ TOLL → balance −= TOLL, `charge_done` pulse, `charge_tag` updated, HOLD with `10`; else HOLD with `11`, balance unchanged. Balance never wraps.
- HOLD: `valid_Epass` held; fall → IDLE, `valid_Epass=00` from the next edge.
- `tag_valid` outside WAIT_TAG ignored. `acct_wr_en` honoured only in IDLE; silently ignored when `acct_busy`.
- Reset: state IDLE, all entry valid bits 0, balances 0, `valid_Epass=00`, `charge_done=0`, `charge_tag=0`, `acct_busy=0`. Reset mid-transaction aborts without charge.

## Timing
- Sensor rise at input → WAIT_TAG 1 cycle later (after `s2_q` edge).
- `tag_valid` sampled at edge t: entry k compared in cycle t+1+k; match → CHARGE at t+2+k; `valid_Epass`/`charge_done` visible after edge t+3+k.
- Unknown tag: `01` visible N_ACCT+1 cycles after `tag_valid` sample.
- Timeout: `01` visible TAG_TIMEOUT+1 cycles after entering WAIT_TAG.
- Rise and fall in same sampled cycle impossible (registered); fall in same cycle as `tag_valid` → fall wins, IDLE.
- All outputs registered except `acct_rd_bal`, `acct_busy` (decoded from state register).

## Structure
- Shared package `etc_pkg`: `epass_code_t` enum (`EP_NONE=2'b00`, `EP_UNKNOWN=2'b01`, `EP_OK=2'b10`, `EP_LOWBAL=2'b11`), validator state enum.
- Sub-module `epass_acct_table`: N_ACCT×{valid, tag, balance} registers; provisioning write port, search read port, charge write-back port, debug read port; async-reset clear.

## Test plan
- Provision idx2 tag 0x5A bal 120; sensor2 rise, tag 0x5A → `valid_Epass=10` 5 cycles after tag, `charge_done` pulse, `acct_rd_bal[2]=70`; fall → `00`.
- Three passes of 0x5A from 120 → `10`, `10`, `11`; balance 70, 20, 20; only two `charge_done` pulses.
- Tag 0x33 not provisioned → `01` 9 cycles after tag, no balance change.
- No tag after rise → `01` after 65 cycles; held until fall.
- Fall during SEARCH, and `reset_n` low during HOLD → `valid_Epass=00`, balance unchanged (reset: table cleared, `acct_rd_bal=0`).
- `acct_wr_en` during HOLD (idx2, bal 999) → ignored; same write in IDLE → `acct_rd_bal[2]=999`.

Source files
------------

// File: rtl/etc_pkg.sv
// Shared types for the non-stop ETC path: E-pass verdict codes and the
// validator FSM state encoding.
package etc_pkg;

    typedef enum logic [1:0] {
        EP_NONE    = 2'b00,
        EP_UNKNOWN = 2'b01,
        EP_OK      = 2'b10,
        EP_LOWBAL  = 2'b11
    } epass_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_TAG = 3'd1,
        ST_SEARCH   = 3'd2,
        ST_CHARGE   = 3'd3,
        ST_HOLD     = 3'd4
    } val_state_t;

endpackage

// File: rtl/epass_acct_table.sv
// Account table: N_ACCT entries of {valid, tag, balance} with provisioning
// write, search read, charge write-back and debug read ports.
module epass_acct_table #(
    parameter int TAG_W  = 8,
    parameter int BAL_W  = 16,
    parameter int N_ACCT = 8,
    parameter int IDX_W  = $clog2(N_ACCT)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [BAL_W-1:0] wr_bal,
    input  logic [IDX_W-1:0] srch_idx,
    output logic             srch_valid,
    output logic [TAG_W-1:0] srch_tag,
    input  logic [IDX_W-1:0] chg_idx,
    output logic [BAL_W-1:0] chg_bal,
    input  logic             upd_en,
    input  logic [BAL_W-1:0] upd_bal,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [BAL_W-1:0] rd_bal
);

    logic [N_ACCT-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q [N_ACCT];
    logic [BAL_W-1:0]  bal_q [N_ACCT];

    // Provisioning and charge write-back are never active together (the
    // validator only provisions in IDLE), so their order here is arbitrary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < N_ACCT; i++) begin
                tag_q[i] <= '0;
                bal_q[i] <= '0;
            end
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            bal_q[wr_idx]   <= wr_bal;
        end else if (upd_en) begin
            bal_q[chg_idx]  <= upd_bal;
        end
    end

    assign srch_valid = valid_q[srch_idx];
    assign srch_tag   = tag_q[srch_idx];
    assign chg_bal    = bal_q[chg_idx];
    assign rd_bal     = bal_q[rd_idx];

endmodule

// File: rtl/epass_validator.sv
// E-pass validator: on a sensor-2 arrival, waits for a tag, searches the
// account table one entry per cycle, charges the toll and holds the verdict.
module epass_validator
    import etc_pkg::*;
#(
    parameter int TAG_W       = 8,
    parameter int BAL_W       = 16,
    parameter int N_ACCT      = 8,
    parameter int TOLL        = 50,
    parameter int TAG_TIMEOUT = 64,
    parameter int IDX_W       = $clog2(N_ACCT)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sensor2,
    input  logic             tag_valid,
    input  logic [TAG_W-1:0] tag_id,
    input  logic             acct_wr_en,
    input  logic [IDX_W-1:0] acct_wr_idx,
    input  logic [TAG_W-1:0] acct_wr_tag,
    input  logic [BAL_W-1:0] acct_wr_bal,
    input  logic [IDX_W-1:0] acct_rd_idx,
    output logic [BAL_W-1:0] acct_rd_bal,
    output logic             acct_busy,
    output logic [1:0]       valid_Epass,
    output logic             charge_done,
    output logic [TAG_W-1:0] charge_tag,
    output logic [2:0]       dbg_state
);

    localparam int CNT_W = $clog2(TAG_TIMEOUT + 1);

    val_state_t       state_q, state_d;
    epass_code_t      verdict_q, verdict_d;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] hit_q, hit_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             pend_q, pend_d;
    logic             match_q, match_d;
    logic             last_q, last_d;
    logic             charge_done_d;
    logic [TAG_W-1:0] charge_tag_q, charge_tag_d;
    logic             tbl_wr_en, upd_en;
    logic             srch_valid;
    logic [TAG_W-1:0] srch_tag;
    logic [BAL_W-1:0] chg_bal;
    logic             rise, fall;

    assign rise = sensor2 & ~s2_q;
    assign fall = ~sensor2 & s2_q;

    epass_acct_table #(
        .TAG_W (TAG_W),
        .BAL_W (BAL_W),
        .N_ACCT(N_ACCT),
        .IDX_W (IDX_W)
    ) u_table (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (tbl_wr_en),
        .wr_idx    (acct_wr_idx),
        .wr_tag    (acct_wr_tag),
        .wr_bal    (acct_wr_bal),
        .srch_idx  (idx_q),
        .srch_valid(srch_valid),
        .srch_tag  (srch_tag),
        .chg_idx   (hit_q),
        .chg_bal   (chg_bal),
        .upd_en    (upd_en),
        .upd_bal   (chg_bal - BAL_W'(TOLL)),
        .rd_idx    (acct_rd_idx),
        .rd_bal    (acct_rd_bal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            verdict_q    <= EP_NONE;
            s2_q         <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            hit_q        <= '0;
            tag_q        <= '0;
            pend_q       <= 1'b0;
            match_q      <= 1'b0;
            last_q       <= 1'b0;
            charge_done  <= 1'b0;
            charge_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            verdict_q    <= verdict_d;
            s2_q         <= sensor2;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            hit_q        <= hit_d;
            tag_q        <= tag_d;
            pend_q       <= pend_d;
            match_q      <= match_d;
            last_q       <= last_d;
            charge_done  <= charge_done_d;
            charge_tag_q <= charge_tag_d;
        end
    end

    // tag_valid is a one-cycle strobe with no back-pressure: tag_id is taken
    // only on the edge it is high while in WAIT_TAG, and dropped otherwise.
    // SEARCH compares are registered (match_q/last_q describe entry hit_q),
    // so a decision lands one cycle after the entry is read.
    always_comb begin
        state_d       = state_q;
        verdict_d     = verdict_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        hit_d         = hit_q;
        tag_d         = tag_q;
        pend_d        = pend_q;
        match_d       = match_q;
        last_d        = last_q;
        charge_done_d = 1'b0;
        charge_tag_d  = charge_tag_q;
        tbl_wr_en     = 1'b0;
        upd_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                verdict_d = EP_NONE;
                tbl_wr_en = acct_wr_en;
                if (rise) begin
                    state_d = ST_WAIT_TAG;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_TAG: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (tag_valid) begin
                    state_d = ST_SEARCH;
                    tag_d   = tag_id;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end else if (cnt_q == CNT_W'(TAG_TIMEOUT)) begin
                    state_d   = ST_HOLD;
                    verdict_d = EP_UNKNOWN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEARCH: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (pend_q && match_q) begin
                    state_d = ST_CHARGE;
                end else if (pend_q && last_q) begin
                    state_d   = ST_HOLD;
                    verdict_d = EP_UNKNOWN;
                end else begin
                    match_d = srch_valid && (srch_tag == tag_q);
                    last_d  = (idx_q == IDX_W'(N_ACCT - 1));
                    hit_d   = idx_q;
                    pend_d  = 1'b1;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_CHARGE: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                    if (chg_bal >= BAL_W'(TOLL)) begin
                        upd_en        = 1'b1;
                        charge_done_d = 1'b1;
                        charge_tag_d  = tag_q;
                        verdict_d     = EP_OK;
                    end else begin
                        verdict_d = EP_LOWBAL;
                    end
                end
            end
            ST_HOLD: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    verdict_d = EP_NONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                verdict_d = EP_NONE;
            end
        endcase
        if (state_d == ST_IDLE) begin
            verdict_d = EP_NONE;
        end
    end

    assign acct_busy   = (state_q != ST_IDLE);
    assign valid_Epass = verdict_q;
    assign charge_tag  = charge_tag_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_epass_validator.sv
// Directed bench for epass_validator: provisioning, charged/low-balance/unknown
// passes, tag timeout, aborts by sensor fall and by reset, write gating.
module tb_epass_validator;
    import etc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sensor2;
    logic        tag_valid;
    logic [7:0]  tag_id;
    logic        acct_wr_en;
    logic [2:0]  acct_wr_idx;
    logic [7:0]  acct_wr_tag;
    logic [15:0] acct_wr_bal;
    logic [2:0]  acct_rd_idx;
    logic [15:0] acct_rd_bal;
    logic        acct_busy;
    logic [1:0]  valid_Epass;
    logic        charge_done;
    logic [7:0]  charge_tag;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (charge_done) pulses <= pulses + 1;
    end

    epass_validator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sensor2    (sensor2),
        .tag_valid  (tag_valid),
        .tag_id     (tag_id),
        .acct_wr_en (acct_wr_en),
        .acct_wr_idx(acct_wr_idx),
        .acct_wr_tag(acct_wr_tag),
        .acct_wr_bal(acct_wr_bal),
        .acct_rd_idx(acct_rd_idx),
        .acct_rd_bal(acct_rd_bal),
        .acct_busy  (acct_busy),
        .valid_Epass(valid_Epass),
        .charge_done(charge_done),
        .charge_tag (charge_tag),
        .dbg_state  (dbg_state)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic acct_write(input logic [2:0] idx, input logic [7:0] tag, input logic [15:0] bal);
        acct_wr_en  = 1'b1;
        acct_wr_idx = idx;
        acct_wr_tag = tag;
        acct_wr_bal = bal;
        tick();
        acct_wr_en  = 1'b0;
    endtask

    // One full pass: rise, tag, verdict exactly lat cycles after the tag edge, fall.
    task automatic run_pass(input string name, input logic [7:0] tag, input int lat,
                            input logic [1:0] exp_v, input logic [15:0] exp_bal);
        sensor2 = 1'b1;
        tick();
        check({name, "_busy"}, acct_busy, 1);
        tag_valid = 1'b1;
        tag_id    = tag;
        tick();
        tag_valid = 1'b0;
        tick(lat - 1);
        check({name, "_early"}, valid_Epass, 2'b00);
        tick();
        check({name, "_verdict"}, valid_Epass, exp_v);
        check({name, "_pulse"}, charge_done, (exp_v == 2'b10));
        check({name, "_bal"}, acct_rd_bal, exp_bal);
        tick(3);
        check({name, "_held"}, valid_Epass, exp_v);
        sensor2 = 1'b0;
        tick();
        check({name, "_clear"}, valid_Epass, 2'b00);
        check({name, "_idle"}, acct_busy, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        sensor2     = 1'b0;
        tag_valid   = 1'b0;
        tag_id      = '0;
        acct_wr_en  = 1'b0;
        acct_wr_idx = '0;
        acct_wr_tag = '0;
        acct_wr_bal = '0;
        acct_rd_idx = 3'd2;
        tick(2);
        check("rst_valid", valid_Epass, 2'b00);
        check("rst_busy", acct_busy, 0);
        check("rst_done", charge_done, 0);
        check("rst_ctag", charge_tag, 8'h00);
        check("rst_bal", acct_rd_bal, 16'd0);
        reset_n = 1'b1;
        tick();

        acct_write(3'd2, 8'h5A, 16'd120);
        check("prov_bal", acct_rd_bal, 16'd120);

        // tag strobe while idle must not start anything
        tag_valid = 1'b1;
        tag_id    = 8'h5A;
        tick();
        tag_valid = 1'b0;
        check("idle_tag_busy", acct_busy, 0);
        check("idle_tag_valid", valid_Epass, 2'b00);

        run_pass("p1", 8'h5A, 5, 2'b10, 16'd70);
        check("p1_ctag", charge_tag, 8'h5A);
        run_pass("p2", 8'h5A, 5, 2'b10, 16'd20);
        run_pass("p3", 8'h5A, 5, 2'b11, 16'd20);
        check("two_pulses", pulses, 2);

        run_pass("unk", 8'h33, 9, 2'b01, 16'd20);
        check("unk_pulses", pulses, 2);

        // timeout, then a write attempt while holding
        sensor2 = 1'b1;
        tick();
        tick(64);
        check("to_early", valid_Epass, 2'b00);
        tick();
        check("to_verdict", valid_Epass, 2'b01);
        acct_write(3'd2, 8'h5A, 16'd999);
        check("hold_wr_ignored", acct_rd_bal, 16'd20);
        tick(5);
        check("to_held", valid_Epass, 2'b01);
        sensor2 = 1'b0;
        tick();
        check("to_clear", valid_Epass, 2'b00);
        acct_write(3'd2, 8'h5A, 16'd999);
        check("idle_wr", acct_rd_bal, 16'd999);

        // sensor falls mid-search
        p0 = pulses;
        sensor2 = 1'b1;
        tick();
        tag_valid = 1'b1;
        tag_id    = 8'h5A;
        tick();
        tag_valid = 1'b0;
        tick();
        check("srch_state", dbg_state, ST_SEARCH);
        sensor2 = 1'b0;
        tick();
        check("srch_abort_busy", acct_busy, 0);
        tick(6);
        check("srch_abort_valid", valid_Epass, 2'b00);
        check("srch_abort_pulses", pulses, p0);
        check("srch_abort_bal", acct_rd_bal, 16'd999);

        // fall coincident with the tag strobe: fall wins
        sensor2 = 1'b1;
        tick();
        sensor2   = 1'b0;
        tag_valid = 1'b1;
        tick();
        tag_valid = 1'b0;
        check("fall_wins_busy", acct_busy, 0);
        tick(8);
        check("fall_wins_bal", acct_rd_bal, 16'd999);

        // reset while holding a charged verdict
        sensor2 = 1'b1;
        tick();
        tag_valid = 1'b1;
        tag_id    = 8'h5A;
        tick();
        tag_valid = 1'b0;
        tick(5);
        check("rh_verdict", valid_Epass, 2'b10);
        check("rh_bal", acct_rd_bal, 16'd949);
        tick(2);
        reset_n = 1'b0;
        #1;
        check("rh_valid", valid_Epass, 2'b00);
        check("rh_busy", acct_busy, 0);
        check("rh_tbl", acct_rd_bal, 16'd0);
        check("rh_ctag", charge_tag, 8'h00);
        sensor2 = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(2);
        check("rh_after_valid", valid_Epass, 2'b00);
        check("rh_after_bal", acct_rd_bal, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
